alu_packet_ctrl: RTL

//  Command sequencer between the UART byte streams and the ALU datapath.
//  - Parses framed packets from UART RX: [opcode, rsvd, len_lo, len_hi, payload].
//  - Echoes payloads, or reduces 32-bit little-endian operands through the ALU.
//  - Returns the 32-bit result to UART TX as 4 bytes, LSB first.
//  - Sits between uart_rx/uart_tx and the multi-cycle mul/div units; add is done internally.

---
 rtl/alu_ctrl_pkg.sv | 31 +++
 rtl/alu_result_ser.sv | 46 ++++
 rtl/alu_packet_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, FSM states and constants for the ALU packet controller.
package alu_ctrl_pkg;

   typedef enum logic [7:0] {
      OP_ECHO = 8'hEC,
      OP_ADD  = 8'hA0,
      OP_MUL  = 8'hA1,
      OP_DIV  = 8'hA2
   } opcode_e;

   typedef enum logic [3:0] {
      HDR_OP,
      HDR_RSV,
      HDR_LLO,
      HDR_LHI,
      ECHO,
      OPND,
      EXEC,
      WAIT,
      SEND,
      DRAIN
   } state_e;

   localparam logic [7:0]  ERR_BYTE    = 8'hEE;
   localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

   function automatic logic is_alu_op(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_result_ser.sv
// Serializes a 32-bit word LSB-first onto a valid/ready byte stream;
// load_last selects how many bytes (0 = one byte, 3 = four bytes).
module alu_result_ser (
   input  logic        clk,
   input  logic        srst,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [1:0]  load_last,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        done
);

   logic [31:0] shift_reg;
   logic [1:0]  cnt_reg;
   logic        valid_reg;
   logic        xfer;

   assign xfer = valid_reg & tx_ready;

   always_ff @(posedge clk) begin
      if (srst) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         shift_reg <= load_data;
         cnt_reg   <= load_last;
         valid_reg <= 1'b1;
      end else if (xfer) begin
         if (cnt_reg == 2'd0) begin
            valid_reg <= 1'b0;
            shift_reg <= '0;
         end else begin
            shift_reg <= {8'h00, shift_reg[31:8]};
            cnt_reg   <= cnt_reg - 2'd1;
         end
      end
   end

   assign tx_data  = shift_reg[7:0];
   assign tx_valid = valid_reg;
   assign done     = xfer & (cnt_reg == 2'd0);

endmodule

// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between UART RX/TX and the mul/div units (add is internal).
// Define ALU_CTRL_ERR_RESP_EN to answer dropped error packets with one 0xEE byte.
module alu_packet_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic        alu_req_v_o,
   input  logic        alu_req_r_i,
   input  logic [31:0] alu_rsp_i,
   input  logic        alu_rsp_v_i,
   output logic        alu_rsp_r_o
);

`ifdef ALU_CTRL_ERR_RESP_EN
   localparam bit ERR_RESP = 1'b1;
`else
   localparam bit ERR_RESP = 1'b0;
`endif

   state_e      state_reg;
   logic [7:0]  op_reg;
   logic [7:0]  len_lo_reg;
   logic [15:0] rem_reg;
   logic        first_reg;
   logic [31:0] opnd_reg;
   logic [31:0] acc_reg;
   logic        alu_op_reg;
   logic [31:0] alu_a_reg;
   logic [31:0] alu_b_reg;
   logic        alu_req_v_reg;
   logic        alu_rsp_r_reg;
   logic        ser_load_reg;
   logic        ser_err_reg;
   logic        armed_reg;

   logic        rx_fire;
   logic [15:0] len_full;
   logic        len_ok_alu;
   logic [31:0] opnd_full;
   logic [31:0] sum;
   logic [7:0]  ser_data;
   logic        ser_valid;
   logic        ser_done;

   assign rx_fire    = rx_valid_i & rx_ready_o;
   assign len_full   = {rx_data_i, len_lo_reg};
   assign len_ok_alu = (len_full != 16'd0) && (len_full[1:0] == 2'b00) && (len_full <= MAX_LEN);
   // Operand bytes shift in from the top, so after four bytes the first is at [7:0].
   assign opnd_full  = {rx_data_i, opnd_reg[31:8]};
   assign sum        = acc_reg + opnd_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= HDR_OP;
         op_reg        <= '0;
         len_lo_reg    <= '0;
         rem_reg       <= '0;
         first_reg     <= 1'b0;
         opnd_reg      <= '0;
         acc_reg       <= '0;
         alu_op_reg    <= 1'b0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_req_v_reg <= 1'b0;
         alu_rsp_r_reg <= 1'b0;
         ser_load_reg  <= 1'b0;
         ser_err_reg   <= 1'b0;
         armed_reg     <= 1'b0;
      end else begin
         armed_reg    <= 1'b1;
         ser_load_reg <= 1'b0;
         case (state_reg)
            HDR_OP: if (rx_fire) begin
               op_reg    <= rx_data_i;
               state_reg <= HDR_RSV;
            end
            HDR_RSV: if (rx_fire) state_reg <= HDR_LLO;
            HDR_LLO: if (rx_fire) begin
               len_lo_reg <= rx_data_i;
               state_reg  <= HDR_LHI;
            end
            HDR_LHI: if (rx_fire) begin
               rem_reg   <= len_full;
               first_reg <= 1'b1;
               if (op_reg == OP_ECHO && len_full <= MAX_LEN) begin
                  state_reg <= (len_full == 16'd0) ? HDR_OP : ECHO;
               end else if (is_alu_op(op_reg) && len_ok_alu) begin
                  state_reg <= OPND;
               end else if (len_full != 16'd0) begin
                  state_reg <= DRAIN;
               end else if (ERR_RESP) begin
                  ser_err_reg  <= 1'b1;
                  ser_load_reg <= 1'b1;
                  state_reg    <= SEND;
               end else begin
                  state_reg <= HDR_OP;
               end
            end
            ECHO: if (rx_fire) begin
               rem_reg <= rem_reg - 16'd1;
               if (rem_reg == 16'd1) state_reg <= HDR_OP;
            end
            OPND: if (rx_fire) begin
               rem_reg  <= rem_reg - 16'd1;
               opnd_reg <= opnd_full;
               // rem == 1 mod 4 marks the final byte of an operand.
               if (rem_reg[1:0] == 2'b01) begin
                  if (first_reg) begin
                     first_reg <= 1'b0;
                     acc_reg   <= opnd_full;
                     if (rem_reg == 16'd1) begin
                        ser_err_reg  <= 1'b0;
                        ser_load_reg <= 1'b1;
                        state_reg    <= SEND;
                     end
                  end else begin
                     state_reg <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (!alu_req_v_reg) begin
                  if (op_reg == OP_ADD || (op_reg == OP_DIV && opnd_reg == 32'd0)) begin
                     acc_reg <= (op_reg == OP_ADD) ? sum : DIV0_RESULT;
                     if (rem_reg == 16'd0) begin
                        ser_err_reg  <= 1'b0;
                        ser_load_reg <= 1'b1;
                        state_reg    <= SEND;
                     end else begin
                        state_reg <= OPND;
                     end
                  end else begin
                     alu_req_v_reg <= 1'b1;
                     alu_op_reg    <= (op_reg == OP_DIV);
                     alu_a_reg     <= acc_reg;
                     alu_b_reg     <= opnd_reg;
                  end
               end else if (alu_req_r_i) begin
                  alu_req_v_reg <= 1'b0;
                  alu_rsp_r_reg <= 1'b1;
                  state_reg     <= WAIT;
               end
            end
            WAIT: if (alu_rsp_v_i) begin
               alu_rsp_r_reg <= 1'b0;
               acc_reg       <= alu_rsp_i;
               if (rem_reg == 16'd0) begin
                  ser_err_reg  <= 1'b0;
                  ser_load_reg <= 1'b1;
                  state_reg    <= SEND;
               end else begin
                  state_reg <= OPND;
               end
            end
            SEND: if (ser_done) state_reg <= HDR_OP;
            DRAIN: if (rx_fire) begin
               rem_reg <= rem_reg - 16'd1;
               if (rem_reg == 16'd1) begin
                  if (ERR_RESP) begin
                     ser_err_reg  <= 1'b1;
                     ser_load_reg <= 1'b1;
                     state_reg    <= SEND;
                  end else begin
                     state_reg <= HDR_OP;
                  end
               end
            end
            default: state_reg <= HDR_OP;
         endcase
      end
   end

   alu_result_ser u_ser (
      .clk       (clk_i),
      .srst      (rst_i),
      .load      (ser_load_reg),
      .load_data (ser_err_reg ? {24'h0, ERR_BYTE} : acc_reg),
      .load_last (ser_err_reg ? 2'd0 : 2'd3),
      .tx_ready  (tx_ready_i & (state_reg != ECHO)),
      .tx_data   (ser_data),
      .tx_valid  (ser_valid),
      .done      (ser_done)
   );

   // armed_reg keeps rx_ready low for as long as reset is held.
   always_comb begin
      rx_ready_o = 1'b0;
      tx_valid_o = ser_valid;
      tx_data_o  = ser_data;
      if (armed_reg) begin
         case (state_reg)
            HDR_OP, HDR_RSV, HDR_LLO, HDR_LHI, OPND, DRAIN: rx_ready_o = 1'b1;
            ECHO: begin
               rx_ready_o = tx_ready_i;
               tx_valid_o = rx_valid_i;
               tx_data_o  = rx_data_i;
            end
            default: rx_ready_o = 1'b0;
         endcase
      end
   end

   assign alu_op_o    = alu_op_reg;
   assign alu_a_o     = alu_a_reg;
   assign alu_b_o     = alu_b_reg;
   assign alu_req_v_o = alu_req_v_reg;
   assign alu_rsp_r_o = alu_rsp_r_reg;

endmodule
